// File: rtl/spec_rollback_ctrl_pkg.sv
// Shared definitions for the rollback controller: recovery state encoding,
// drain-counter width and the width derivations also used by the speculation vector.
package spec_rollback_ctrl_pkg;

  localparam int DRAIN_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KILL    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RESTORE = 3'd3,
    ST_REDIR   = 3'd4
  } state_e;

  function automatic int reg_id_bits(input int num_reg);
    return $clog2(num_reg);
  endfunction

  // One extra bit so level SPEC_DEPTH itself is representable.
  function automatic int spec_level_bits(input int spec_depth);
    return $clog2(spec_depth) + 1;
  endfunction

endpackage

// File: rtl/spec_rollback_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module spec_rollback_ctrl_sat_counter #(
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [CNT_BIT-1:0] cnt
);

  logic [CNT_BIT-1:0] cnt_q;
  logic [CNT_BIT-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/spec_rollback_ctrl.sv
// Misprediction recovery sequencer: squash, drain, restore tag map, redirect fetch,
// holding stall for the whole rollback.
module spec_rollback_ctrl
  import spec_rollback_ctrl_pkg::*;
#(
  parameter int NUM_TAG        = 4,
  parameter int NUM_REG        = 8,
  parameter int SPEC_DEPTH     = 4,
  parameter int PC_BIT         = 4,
  parameter int INST_ID_BIT    = 8,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_BIT        = 16,
  parameter int REG_ID_BIT     = reg_id_bits(NUM_REG),
  parameter int SPEC_LEVEL_BIT = spec_level_bits(SPEC_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          br_pred_vld,
  input  logic                          br_pred_succ,
  input  logic [SPEC_LEVEL_BIT-1:0]     br_pred_fail_level,
  input  logic [NUM_TAG*REG_ID_BIT-1:0] br_pred_fail_tag_map,
  input  logic [PC_BIT-1:0]             br_pred_fail_pc,
  input  logic [INST_ID_BIT-1:0]        br_pred_fail_id,
  output logic                          stall,
  output logic                          kill_vld,
  output logic [SPEC_LEVEL_BIT-1:0]     kill_level,
  output logic                          tag_map_wr_vld,
  output logic [NUM_TAG*REG_ID_BIT-1:0] tag_map_wr_data,
  output logic                          redir_vld,
  input  logic                          redir_rdy,
  output logic [PC_BIT-1:0]             redir_pc,
  output logic [INST_ID_BIT-1:0]        redir_id,
  output logic [CNT_BIT-1:0]            fail_cnt
);

  typedef struct packed {
    logic [SPEC_LEVEL_BIT-1:0]     level;
    logic [NUM_TAG*REG_ID_BIT-1:0] tag_map;
    logic [PC_BIT-1:0]             pc;
    logic [INST_ID_BIT-1:0]        id;
  } rb_info_t;

  localparam logic [DRAIN_BIT-1:0] DRAIN_LOAD = DRAIN_BIT'(FLUSH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [DRAIN_BIT-1:0] drain_q, drain_d;
  rb_info_t             info_q, info_d;
  logic                 mispredict;
  logic                 cnt_inc;

  assign mispredict = br_pred_vld & ~br_pred_succ;

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    info_d         = info_q;
    kill_vld       = 1'b0;
    tag_map_wr_vld = 1'b0;
    redir_vld      = 1'b0;
    cnt_inc        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          info_d.level   = br_pred_fail_level;
          info_d.tag_map = br_pred_fail_tag_map;
          info_d.pc      = br_pred_fail_pc;
          info_d.id      = br_pred_fail_id;
          state_d        = ST_KILL;
        end
      end
      ST_KILL: begin
        kill_vld = 1'b1;
        drain_d  = DRAIN_LOAD;
        state_d  = ST_DRAIN;
      end
      // Loaded with F-1 and left on zero, so the drain spans exactly F cycles.
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_RESTORE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_RESTORE: begin
        tag_map_wr_vld = 1'b1;
        state_d        = ST_REDIR;
      end
      ST_REDIR: begin
        redir_vld = 1'b1;
        if (redir_rdy) begin
          cnt_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      info_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      info_q  <= info_d;
    end
  end

  // Mealy term lets the mispredict cycle itself block issue.
  assign stall           = (state_q != ST_IDLE) | mispredict;
  assign kill_level      = info_q.level;
  assign tag_map_wr_data = info_q.tag_map;
  assign redir_pc        = info_q.pc;
  assign redir_id        = info_q.id;

  spec_rollback_ctrl_sat_counter #(
    .CNT_BIT (CNT_BIT)
  ) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .cnt (fail_cnt)
  );

endmodule
